adder_tree_pipe: RTL and testbench



---
 rtl/adder_tree_pkg.sv | 31 +++
 rtl/adder_tree_level.sv | 39 +++
 rtl/adder_tree_pipe.sv | 109 ++++++++++
 tb/tb_adder_tree_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants and width helpers for the pipelined adder tree.
// Optional accumulator stage is enabled with the ADDER_TREE_ACC_EN macro.
package adder_tree_pkg;

  localparam int DEF_IN_W  = 14;
  localparam int DEF_N_IN  = 4;
  localparam int DEF_ACC_W = 24;

  // Valid/first sideband that travels alongside each pipeline slot.
  typedef struct packed {
    logic valid;
    logic first;
  } side_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int sum_width(input int in_w, input int n_in);
    return in_w + clog2(n_in);
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise-add level: N_WORDS words of IN_W bits in,
// N_WORDS/2 words of IN_W+1 bits out, with sideband and global enable.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int N_WORDS = 4,
  parameter int IN_W    = 14
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  side_t                                src_side,
  input  logic [N_WORDS*IN_W-1:0]              src_data,
  output side_t                                side,
  output logic [(N_WORDS/2)*(IN_W+1)-1:0]      data
);

  localparam int N_OUT = N_WORDS / 2;
  localparam int OUT_W = IN_W + 1;

  logic [N_OUT-1:0][OUT_W-1:0] sum;

  // Operands are zero-extended by one bit so a level can never overflow.
  for (genvar i = 0; i < N_OUT; i++) begin : g_pair
    assign sum[i] = {1'b0, src_data[(2*i)*IN_W +: IN_W]}
                  + {1'b0, src_data[(2*i+1)*IN_W +: IN_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      side <= '0;
      data <= '0;
    end else if (en) begin
      side <= src_side;
      data <= sum;
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined unsigned adder tree with valid/ready and global stall enable.
// Define ADDER_TREE_ACC_EN to add a running accumulator after the tree.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int N_IN  = DEF_N_IN,
  parameter int ACC_W = DEF_ACC_W,
  localparam int LEVELS = clog2(N_IN),
  localparam int SUM_W  = sum_width(IN_W, N_IN),
`ifdef ADDER_TREE_ACC_EN
  localparam int OUT_W  = ACC_W
`else
  localparam int OUT_W  = SUM_W
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data
);

  logic                en;
  side_t               s0_side;
  logic [N_IN*IN_W-1:0] s0_data;

  // Single global enable: the whole pipe moves together or holds together.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_side <= '0;
      s0_data <= '0;
    end else if (en) begin
      s0_side <= '{valid: in_valid, first: in_first};
      s0_data <= in_data;
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NW = N_IN >> (l - 1);
    localparam int WW = IN_W + l - 1;

    side_t                      src_side;
    side_t                      side;
    logic [NW*WW-1:0]           src_data;
    logic [(NW/2)*(WW+1)-1:0]   data;

    if (l == 1) begin : g_src
      assign src_side = s0_side;
      assign src_data = s0_data;
    end else begin : g_src
      assign src_side = g_lvl[l-1].side;
      assign src_data = g_lvl[l-1].data;
    end

    adder_tree_level #(
      .N_WORDS (NW),
      .IN_W    (WW)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .src_side (src_side),
      .src_data (src_data),
      .side     (side),
      .data     (data)
    );
  end

  side_t            tree_side;
  logic [SUM_W-1:0] tree_sum;

  assign tree_side = g_lvl[LEVELS].side;
  assign tree_sum  = g_lvl[LEVELS].data;

`ifdef ADDER_TREE_ACC_EN
  logic             acc_valid;
  logic [ACC_W-1:0] acc;

  // Accumulator only updates on valid slots; bubbles and stalls hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_valid <= 1'b0;
      acc       <= '0;
    end else if (en) begin
      acc_valid <= tree_side.valid;
      if (tree_side.valid)
        acc <= tree_side.first ? ACC_W'(tree_sum) : acc + ACC_W'(tree_sum);
    end
  end

  assign out_valid = acc_valid;
  assign out_data  = acc;
`else
  logic unused_side;

  assign out_valid   = tree_side.valid;
  assign out_data    = tree_sum;
  assign unused_side = ^{tree_side.first, (ACC_W >= SUM_W)};
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe (N_IN=4, IN_W=14): vector table,
// backpressure and reset sequences, then randomized traffic vs a sum model.
module tb_adder_tree_pipe;

  localparam int IN_W = 14;
  localparam int N_IN = 4;
`ifdef ADDER_TREE_ACC_EN
  localparam int ACC_W = 16;
  localparam int OUT_W = ACC_W;
  localparam int LAT   = 4;
  localparam bit ACC   = 1'b1;
`else
  localparam int ACC_W = 24;
  localparam int OUT_W = IN_W + 2;
  localparam int LAT   = 3;
  localparam bit ACC   = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic                  in_first = 1'b0;
  logic [N_IN*IN_W-1:0]  in_data = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [OUT_W-1:0]      out_data;

  adder_tree_pipe #(.IN_W(IN_W), .N_IN(N_IN), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    int     cyc;
    bit     chk_lat;
  } exp_t;

  typedef struct {
    int     w0, w1, w2, w3;
    bit     first;
    longint exp;
  } vec_t;

  exp_t            exp_q[$];
  vec_t            tbl[6];
  longint          acc_m;
  int              cyc;
  int              n_checks;
  int              n_fail;
  bit              prev_stall;
  logic [OUT_W-1:0] prev_data;

  function automatic void check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [N_IN*IN_W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
  endfunction

  // Reference: plain sum of the words, then optional running total mod 2^OUT_W.
  function automatic longint model_sum(input logic [N_IN*IN_W-1:0] d);
    longint s;
    s = 0;
    for (int k = 0; k < N_IN; k++) s += longint'(d[k*IN_W +: IN_W]);
    return s;
  endfunction

  task automatic cycle(input logic v, input logic [N_IN*IN_W-1:0] d, input logic f,
                       input logic ordy, input bit use_t, input longint texp, input bit lat);
    @(posedge clk); #1;
    cyc++;
    in_valid  = v;
    in_data   = d;
    in_first  = f;
    out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("stall_valid", longint'(out_valid), 1);
      check("stall_data", longint'(out_data), longint'(prev_data));
    end
    if (out_valid && !out_ready) check("stall_in_ready", longint'(in_ready), 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_out: got %0d expected no result (cycle %0d)", out_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", longint'(out_data), e.val);
        if (e.chk_lat) check("latency", longint'(cyc - e.cyc), LAT);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (in_valid && in_ready) begin
      exp_t   n;
      longint s;
      s = model_sum(d);
      if (ACC) begin
        acc_m = (f ? s : acc_m + s) % (longint'(1) << OUT_W);
        s = acc_m;
      end
      n.val     = use_t ? texp : s;
      n.cyc     = cyc;
      n.chk_lat = lat;
      exp_q.push_back(n);
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, 1'b0, ordy, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #2;
    check("rst_out_valid_now", longint'(out_valid), 0);
    check("rst_out_data_now", longint'(out_data), 0);
    check("rst_in_ready_now", longint'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    acc_m = 0;
    prev_stall = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_in_ready", longint'(in_ready), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) idle(1'b1);
    check("drain_empty", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N_IN*IN_W-1:0] d;
    n_checks = 0; n_fail = 0; cyc = 0; acc_m = 0; prev_stall = 1'b0; prev_data = '0;

`ifdef ADDER_TREE_ACC_EN
    tbl[0] = '{1111, 1111, 1111, 1111, 1'b1, 4444};
    tbl[1] = '{1111, 1111, 1111, 1111, 1'b0, 8888};
    tbl[2] = '{5555, 5555, 5555, 5555, 1'b1, 22220};
    tbl[3] = '{16383, 16383, 16383, 16383, 1'b1, 65532};
    tbl[4] = '{16383, 16383, 16383, 16383, 1'b0, 65528};
    tbl[5] = '{16383, 16383, 16383, 16383, 1'b0, 65524};
`else
    tbl[0] = '{1111, 1111, 1111, 1111, 1'b1, 4444};
    tbl[1] = '{3333, 3333, 3333, 3333, 1'b0, 13332};
    tbl[2] = '{5555, 5555, 5555, 5555, 1'b0, 22220};
    tbl[3] = '{16383, 16383, 16383, 16383, 1'b0, 65532};
    tbl[4] = '{1, 2, 3, 4, 1'b0, 10};
    tbl[5] = '{16383, 0, 16383, 0, 1'b0, 32766};
`endif

    // Reset, then output must stay quiet with zero data while idle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("idle_out_valid", longint'(out_valid), 0);
      check("idle_out_data", longint'(out_data), 0);
    end

    // Back-to-back vectors with fixed latency and table-given results.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, pack4(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3), tbl[i].first,
            1'b1, 1'b1, tbl[i].exp, 1'b1);
    drain();

    // Backpressure: three beats, stall 4 cycles once the first result shows.
    cycle(1'b1, pack4(100, 200, 300, 400), 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, pack4(7, 8, 9, 10), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, pack4(16383, 1, 2, 3), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 3; i < LAT; i++) idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, pack4(50, 60, 70, 80), 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
    end
    cycle(1'b1, pack4(50, 60, 70, 80), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    check("bp_release_ready", longint'(in_ready), 1);
    drain();

    // Reset with two beats in flight: neither result may ever appear.
    cycle(1'b1, pack4(1000, 1000, 1000, 1000), 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, pack4(2000, 2000, 2000, 2000), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_reset();
    for (int i = 0; i < LAT + 3; i++) begin
      idle(1'b1);
      check("post_rst_quiet", longint'(out_valid), 0);
    end

    // Randomized traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N_IN; k++)
        d[k*IN_W +: IN_W] = ($urandom_range(0, 7) == 0) ? '1 : IN_W'($urandom);
      cycle(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0), 1'b0, 0, 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
